pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and next-fetch-address stage of the MIPS datapath. Consumes the sign-extended, left-shifted-by-2 branch offset and the 26-bit jump index, and forms branch and jump targets. Holds the PC register and drives the instruction-memory fetch address. Handles stalls and memory back-pressure, and latches redirects that arrive while the fetch cannot advance.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `stall` in 1: hazard-unit hold request; the PC must not advance while it is high.
- `imem_ready` in 1: instruction memory accepts the current `pc` this cycle.
- `branch_taken` in 1: resolved taken branch, one-cycle pulse.
- `branch_offset_sh` in 32: sign-extended immediate, already shifted left by 2.
- `redirect_base` in 32: PC+4 of the branch or jump instruction.
- `jump` in 1: unconditional J/JAL, one-cycle pulse.
- `jump_index` in 26: instr[25:0] of the jump.
- `pc` out 32: current fetch address.
- `pc_plus4` out 32: `pc` + 4, combinational.
- `fetch_valid` out 1: `pc` is a valid fetch request this cycle.
- `redirect_pending` out 1: a latched redirect is waiting to be applied.

## Operation
- `advance` = `~stall & imem_ready & started`.
- `started` is an internal register: 0 on reset, set to 1 on the first cycle after reset deasserts.
- Branch target: `redirect_base + branch_offset_sh`, computed modulo 2^32.
- Jump target: `{redirect_base[31:28], jump_index, 2'b00}`.
- If `jump` and `branch_taken` are both high, the jump target is used.
- The target's low 2 bits are forced to 00.
- FSM states:
  - RUN (reset state):
    - On a request (`jump | branch_taken`) with `advance` high: the PC loads the target at the next edge; stay in RUN.
    - On a request with `advance` low: latch the target into `pend_target` and go to PEND.
    - With no request: if `advance` is high, the PC loads `pc_plus4`; otherwise the PC holds.
  - PEND:
    - New `jump`/`branch_taken` pulses are ignored. The older redirect wins, because the younger instruction is on the wrong path.
    - When `advance` is high: the PC loads `pend_target` and the FSM returns to RUN.
    - Otherwise the PC holds.
- `redirect_pending` = (state == PEND).
- `fetch_valid` = `started & ~stall`. It does not depend on `imem_ready`: the request stays asserted until accepted.
- PC increment wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- All state updates on the rising edge of `clk`. `pc_plus4` and `fetch_valid` are combinational from registers and `stall`.
- Reset values while `reset` is high at an edge:
  - `pc` = `RESET_PC`, `pc_plus4` = `RESET_PC` + 4.
  - `started` = 0, so `fetch_valid` = 0.
  - state = RUN, so `redirect_pending` = 0.
  - `pend_target` = 0.
- First fetch: `fetch_valid` rises one cycle after `reset` deasserts, with `pc` = `RESET_PC`.
- Redirect latency: a request in cycle N with `advance` high gives `pc` = target in cycle N+1.
- If `advance` is low in cycle N, `pc` = target in the cycle after the first cycle ≥N+1 in which `advance` is high.
- Reset asserted in PEND: the pending target is discarded, state returns to RUN and `pc` returns to `RESET_PC`.
- Back-to-back redirects in RUN with `advance` high each cycle: each one is applied in turn. PEND is never entered.
- Stall and redirect in the same cycle: the redirect is latched (PEND) and `pc` holds.

## Test plan
- Reset, then release with `imem_ready`=1, `stall`=0:
  - Reset cycle: `fetch_valid`=0, `pc`=0.
  - Following cycles: `pc` = 0, 4, 8, 12.
- Branch in RUN: `redirect_base`=32'h0000_0104, `branch_offset_sh`=32'hFFFF_FFF0, `branch_taken` pulse with `advance` high -> next `pc`=32'h0000_00F4.
- Jump with back-pressure: `jump`, `redirect_base`=32'h4000_0010, `jump_index`=26'h000_0040, `imem_ready`=0 for 3 cycles.
  - `redirect_pending`=1 and `pc` holds for those 3 cycles.
  - `pc`=32'h4000_0100 one cycle after `imem_ready` rises.
- PEND conflict: a second `branch_taken` arrives while PEND -> it is ignored; the first target is applied.
- Wrap-around: force `pc`=32'hFFFF_FFFC via a jump target plus a branch -> next sequential `pc`=0. Simultaneous `jump` and `branch_taken` -> the jump target is chosen.
- Reset mid-PEND: reset asserted while `redirect_pending`=1 -> `pc`=`RESET_PC` and `redirect_pending`=0 at the next edge, and no stale target is applied afterwards.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: hazard/memory controls and redirect inputs in, fetch address and status out.
interface pc_fetch_unit_if;
    logic        stall;
    logic        imem_ready;
    logic        branch_taken;
    logic [31:0] branch_offset_sh;
    logic [31:0] redirect_base;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        redirect_pending;

    modport master (
        output stall, imem_ready, branch_taken, branch_offset_sh,
               redirect_base, jump, jump_index,
        input  pc, pc_plus4, fetch_valid, redirect_pending
    );

    modport slave (
        input  stall, imem_ready, branch_taken, branch_offset_sh,
               redirect_base, jump, jump_index,
        output pc, pc_plus4, fetch_valid, redirect_pending
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and next-fetch-address selection with stall/back-pressure handling
// and a one-deep holding slot for redirects that arrive while fetch cannot advance.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           reset,
    pc_fetch_unit_if.slave bus
);

    typedef enum logic {RUN, PEND} state_t;

    state_t      state, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target, pend_d;
    logic        started;
    logic        advance;
    logic        req;
    logic [31:0] branch_tgt;
    logic [31:0] target;

    assign advance    = ~bus.stall & bus.imem_ready & started;
    assign req        = bus.jump | bus.branch_taken;
    assign branch_tgt = bus.redirect_base + bus.branch_offset_sh;

    // Jump has priority over a simultaneous taken branch.
    always_comb begin
        target = '0;
        if (bus.jump)
            target = {bus.redirect_base[31:28], bus.jump_index, 2'b00};
        else
            target = {branch_tgt[31:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc_q        <= RESET_PC;
            pend_target <= '0;
            started     <= 1'b0;
        end else begin
            state       <= state_d;
            pc_q        <= pc_d;
            pend_target <= pend_d;
            started     <= 1'b1;
        end
    end

    // In PEND new requests are dropped: the older redirect is the correct path.
    always_comb begin
        state_d = state;
        pc_d    = pc_q;
        pend_d  = pend_target;
        unique case (state)
            RUN: begin
                if (req) begin
                    if (advance) begin
                        pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = PEND;
                    end
                end else if (advance) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            PEND: begin
                if (advance) begin
                    pc_d    = pend_target;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign bus.pc               = pc_q;
    assign bus.pc_plus4         = pc_q + 32'd4;
    assign bus.fetch_valid      = started & ~bus.stall;
    assign bus.redirect_pending = (state == PEND);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboarded bench for pc_fetch_unit: directed scenarios with hand-computed PCs,
// then randomized traffic checked against a behavioural model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    pc_fetch_unit_if bus();

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        fv;
        logic        rp;
        logic        has_abs;
        logic [31:0] abs_pc;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0;
    int   nerr = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_started;
    logic        m_pend_valid;
    logic [31:0] m_pend;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc", bus.pc, e.pc);
            chk("pc_plus4", bus.pc_plus4, e.pc4);
            chk("fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, e.fv});
            chk("redirect_pending", {31'b0, bus.redirect_pending}, {31'b0, e.rp});
            if (e.has_abs)
                chk("pc_directed", bus.pc, e.abs_pc);
        end
    end

    function automatic logic [31:0] redirect_target(input logic jp, input logic [31:0] base,
                                                    input logic [31:0] off, input logic [25:0] idx);
        logic [31:0] t;
        if (jp) t = {base[31:28], idx, 2'b00};
        else    t = (base + off) & 32'hFFFF_FFFC;
        return t;
    endfunction

    // One cycle: apply inputs, queue expected outputs, clock, update the model.
    task automatic step(input logic rst, input logic stl, input logic rdy,
                        input logic br, input logic jp,
                        input logic [31:0] base, input logic [31:0] off, input logic [25:0] idx,
                        input logic has_abs, input logic [31:0] abs_pc);
        exp_t e;
        logic adv;
        reset                = rst;
        bus.stall            = stl;
        bus.imem_ready       = rdy;
        bus.branch_taken     = br;
        bus.jump             = jp;
        bus.redirect_base    = base;
        bus.branch_offset_sh = off;
        bus.jump_index       = idx;
        e.pc      = m_pc;
        e.pc4     = m_pc + 32'd4;
        e.fv      = m_started & ~stl;
        e.rp      = m_pend_valid;
        e.has_abs = has_abs;
        e.abs_pc  = abs_pc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        adv = m_started & ~stl & rdy;
        if (rst) begin
            m_pc = RST_PC; m_started = 1'b0; m_pend_valid = 1'b0;
        end else begin
            if (m_pend_valid) begin
                if (adv) begin m_pc = m_pend; m_pend_valid = 1'b0; end
            end else if (br | jp) begin
                if (adv) m_pc = redirect_target(jp, base, off, idx);
                else begin m_pend = redirect_target(jp, base, off, idx); m_pend_valid = 1'b1; end
            end else if (adv) begin
                m_pc = m_pc + 32'd4;
            end
            m_started = 1'b1;
        end
    endtask

    task automatic idle(input logic has_abs, input logic [31:0] abs_pc);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, has_abs, abs_pc);
    endtask

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0; bus.imem_ready = 1'b1; bus.branch_taken = 1'b0; bus.jump = 1'b0;
        bus.redirect_base = '0; bus.branch_offset_sh = '0; bus.jump_index = '0;
        m_pc = RST_PC; m_started = 1'b0; m_pend_valid = 1'b0; m_pend = '0;
        @(posedge clk);
        #1;

        // Reset and sequential fetch
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h0);
        idle(1'b1, 32'h0);
        idle(1'b1, 32'h0);
        idle(1'b1, 32'h4);
        idle(1'b1, 32'h8);
        // Taken branch with advance high
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'hFFFF_FFF0, '0, 1'b1, 32'hC);
        idle(1'b1, 32'h0000_00F4);
        // Jump under back-pressure, plus a younger branch while pending
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4000_0010, '0, 26'h000_0040, 1'b1, 32'h0000_00F8);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0400, '0, 1'b1, 32'h0000_00F8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h0000_00F8);
        idle(1'b1, 32'h0000_00F8);
        idle(1'b1, 32'h4000_0100);
        idle(1'b1, 32'h4000_0104);
        // Wrap-around via jump then branch
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hF000_0000, '0, 26'h3FF_FFFC, 1'b1, 32'h4000_0108);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0000_000C, '0, 1'b1, 32'hFFFF_FFF0);
        idle(1'b1, 32'hFFFF_FFFC);
        idle(1'b1, 32'h0);
        // Simultaneous jump and branch: jump wins
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_0100, 26'h000_0010, 1'b1, 32'h4);
        idle(1'b1, 32'h0000_0040);
        // Stall with redirect latches it; reset then discards it
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0200, '0, 1'b1, 32'h0000_0044);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h0000_0044);
        idle(1'b1, 32'h0);
        idle(1'b1, 32'h0);
        idle(1'b1, 32'h4);
        idle(1'b1, 32'h8);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] base, off;
            logic [25:0] idx;
            base = $urandom;
            off  = {{14{1'b0}}, 18'($urandom)} << 2;
            if ($urandom_range(1, 0) == 1) off = -off;
            idx  = 26'($urandom);
            step($urandom_range(99, 0) < 2,
                 $urandom_range(99, 0) < 25,
                 $urandom_range(99, 0) < 70,
                 $urandom_range(99, 0) < 15,
                 $urandom_range(99, 0) < 10,
                 base, off, idx, 1'b0, '0);
        end

        begin
            int budget = 0;
            while (exp_q.size() > 0 && budget < 10) begin
                @(negedge clk);
                budget++;
            end
            #1;
            if (exp_q.size() > 0) begin
                nvec++;
                nerr++;
                $display("FAIL drain: got %0d queued expected 0", exp_q.size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
